// File: rtl/mem_arb_pkg.sv
// Shared widths and state encoding for the memory arbiter slice.
package mem_arb_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 3;
    localparam int MEM_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // rot[0] is the requester at ptr, rot[1] the next one, and so on.
    logic [N-1:0] rot;
    int           off_int;
    int           sum_int;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        int src;
        always_comb begin
            src = int'(ptr) + gi;
            if (src >= N) src = src - N;
            rot[gi] = req[IDX_W'(src)];
        end
    end

    always_comb begin
        off_int = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off_int = i;
        end
        sum_int = int'(ptr) + off_int;
        if (sum_int >= N) sum_int = sum_int - N;
        idx   = IDX_W'(sum_int);
        valid = |rot;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising single-word requests onto one memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              done,
    output logic [DATA_W-1:0]               rdata,
    output logic                            busy,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state_reg;
    logic [PTR_W-1:0]       ptr_reg;
    logic [PTR_W-1:0]       grant_reg;
    logic [NUM_REQ-1:0]     done_reg;
    logic [DATA_W-1:0]      rdata_reg;
    logic                   busy_reg;
    logic                   mem_we_reg;
    logic [ADDR_W-1:0]      mem_addr_reg;
    logic [DATA_W-1:0]      mem_wdata_reg;

    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [PTR_W-1:0]       ptr_next;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant_onehot[gi] = (grant_reg == PTR_W'(gi));
    end

    assign ptr_next = (grant_reg == PTR_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

    // The memory-port registers double as the transaction latch, so later
    // changes on req_* cannot reach the in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            rdata_reg     <= '0;
            busy_reg      <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg     <= pick_idx;
                        mem_we_reg    <= req_we[pick_idx];
                        mem_addr_reg  <= req_addr[pick_idx];
                        mem_wdata_reg <= req_wdata[pick_idx];
                        busy_reg      <= 1'b1;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    mem_we_reg <= 1'b0;
                    rdata_reg  <= mem_rdata;
                    done_reg   <= grant_onehot;
                    state_reg  <= ACK;
                end
                ACK: begin
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    ptr_reg   <= ptr_next;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign done      = done_reg;
    assign rdata     = rdata_reg;
    assign busy      = busy_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one 8-word x 32-bit synchronous-write memory (behavioural or structural variant, identical port contract) between up to four requesters. Each requester issues single-word read or write transactions through a req/done handshake; the arbiter serialises them, drives the memory port for exactly one cycle per transaction and returns read data. It sits between the requester logic and the memory instance in the top level.

## Interface

- NUM_REQ, 2: number of requesters, legal range 2..4
- DATA_W, 32: data width (from package)
- ADDR_W, 3: address width (from package)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- req  in  NUM_REQ  per-requester request, level, held until done
- req_we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read)
- req_addr  in  NUM_REQ x ADDR_W  per-requester word address
- req_wdata  in  NUM_REQ x DATA_W  per-requester write data
- done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- rdata  out  DATA_W  read data, valid in the cycle done is high (shared by all requesters)
- busy  out  1  high in BUSY and ACK states
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr

## Operation

- FSM states IDLE, BUSY, ACK; each state lasts one cycle except IDLE, which holds while req == 0.
- IDLE: if any req bit set, pick winner k by round-robin starting at pointer ptr (first set bit at or after ptr, wrapping modulo NUM_REQ); latch k, req_we[k], req_addr[k], req_wdata[k]; go BUSY.
- BUSY: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we; write commits at the closing edge; mem_rdata captured into rdata register at the closing edge (captured for writes too); go ACK.
- ACK: done[k] = 1; rdata holds captured value; ptr <= (k+1) mod NUM_REQ; go IDLE.
- mem_we is 1 only in BUSY with a latched write; 0 in every other state.
- mem_addr/mem_wdata hold their last driven value outside BUSY (registered outputs, no glitches).
- Requests are sampled only in IDLE; changes to req_* after latching do not affect the in-flight transaction. A req dropped during BUSY/ACK still completes and pulses done.
- Requester must deassert req (or present its next transaction) in the cycle after done; a req still high in IDLE is treated as a new transaction.
- Read-after-write to the same address from different requesters returns the new value (write commits before the later BUSY).

## Timing

- Reset values: state IDLE, ptr 0, done 0, rdata 0, busy 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Request seen in IDLE at cycle t: BUSY in t+1, done/rdata valid in t+2, earliest next grant latched at end of t+3 (IDLE cycle). Throughput one transaction per 3 cycles.
- Simultaneous requests: winner per ptr; losers wait; with all NUM_REQ requesting continuously each is served once every 3*NUM_REQ cycles (no starvation).
- Reset asserted in BUSY: mem_we drops asynchronously, the write is not committed, no done pulse; state returns to IDLE, ptr 0.

## Structure

- Package mem_arb_pkg: DATA_W, ADDR_W, MEM_DEPTH = 8, state enum typedef (IDLE, BUSY, ACK).
- Sub-module rr_pick: combinational round-robin picker (req vector, ptr -> winner index, valid); reused by other arbiters.

## Test plan

- Reset: assert reset mid-run -> all outputs zero immediately, state IDLE, ptr 0.
- Single write then read: req0 write addr 5 data 32'hc0000001, done[0] at t+2; req0 read addr 5 -> rdata 32'hc0000001 with done[0].
- Contention: req0 and req1 both high from IDLE with ptr 0 -> done[0] first, done[1] three cycles later; repeat with ptr 1 -> requester 1 first.
- Fairness: NUM_REQ=4, all requesting continuously for 24 cycles -> exactly two done pulses per requester, order 0,1,2,3,0,1,2,3.
- Cross-requester RAW: req1 writes addr 7 = 32'hdeadbeef, req0 then reads addr 7 -> 32'hdeadbeef; mem_we high in exactly one cycle.
- Abort: reset pulse during BUSY of write addr 2 = 32'h1234 -> later read addr 2 returns prior value, no done pulse for aborted transaction.
